// File: rtl/pic_8259_lite.sv
// Single 8259-style interrupt controller: edge-triggered IR0-IR7, fixed priority (IR0 highest),
// ICW1/2/3/4 init sequence, OCW1/2/3 control, in-service tracking until EOI or auto-EOI.
module pic_8259_lite #(
  parameter logic [7:0] RESET_VECTOR_BASE = 8'h08,
  parameter logic [7:0] RESET_MASK        = 8'hFF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       io_address,
  input  logic       io_read,
  output logic [7:0] io_readdata,
  input  logic       io_write,
  input  logic [7:0] io_writedata,
  input  logic [7:0] irq_in,
  output logic       interrupt_do,
  output logic [7:0] interrupt_vector,
  input  logic       interrupt_done
);

  localparam logic [1:0] ST_READY = 2'd0;
  localparam logic [1:0] ST_ICW2  = 2'd1;
  localparam logic [1:0] ST_ICW3  = 2'd2;
  localparam logic [1:0] ST_ICW4  = 2'd3;

  logic [1:0] state, state_next;
  logic       sngl, ic4, aeoi, read_sel;
  logic [4:0] base;
  logic [7:0] imr, irr, isr, irq_last;
  logic       io_read_last;

  logic       wr0, wr1, icw1, ocw1, ocw2, ocw3, eoi_ns, eoi_sp;
  logic       rd_valid, ack;
  logic [2:0] idx;
  logic [7:0] ack_mask, pend, irr_next, isr_eoi, isr_next;
  logic [3:0] p, s;
  logic       do_next;

  // Lowest set bit index of v, or 8 when v is empty.
  function automatic logic [3:0] lowest_set(input logic [7:0] v);
    logic [3:0] r;
    r = 4'd8;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) r = 4'(i);
    end
    return r;
  endfunction

  assign wr0      = io_write & ~io_address;
  assign wr1      = io_write & io_address;
  assign icw1     = wr0 & io_writedata[4];
  assign ocw1     = (state == ST_READY) & wr1;
  assign ocw2     = (state == ST_READY) & wr0 & (io_writedata[4:3] == 2'b00);
  assign ocw3     = (state == ST_READY) & wr0 & (io_writedata[4:3] == 2'b01);
  assign eoi_ns   = ocw2 & (io_writedata[7:5] == 3'b001);
  assign eoi_sp   = ocw2 & (io_writedata[7:5] == 3'b011);
  assign rd_valid = io_read & ~io_read_last;
  assign ack      = interrupt_done & interrupt_do;
  assign idx      = interrupt_vector[2:0];
  assign ack_mask = ack ? (8'd1 << idx) : 8'd0;
  assign pend     = irr & ~imr;
  assign p        = lowest_set(pend);
  assign s        = lowest_set(isr);

  // Init sequence next state
  always_comb begin
    state_next = state;
    if (icw1) begin
      state_next = ST_ICW2;
    end else if (wr1) begin
      case (state)
        ST_ICW2: state_next = !sngl ? ST_ICW3 : (ic4 ? ST_ICW4 : ST_READY);
        ST_ICW3: state_next = ic4 ? ST_ICW4 : ST_READY;
        ST_ICW4: state_next = ST_READY;
        default: state_next = state;
      endcase
    end
  end

  // Request/in-service update; EOI applies before the acknowledge sets ISR
  always_comb begin
    irr_next = (irr & irq_in & ~ack_mask) | (irq_in & ~irq_last);
    isr_eoi  = isr;
    if (eoi_ns) isr_eoi = isr & (isr - 8'd1);
    if (eoi_sp) isr_eoi = isr & ~(8'd1 << io_writedata[2:0]);
    isr_next = isr_eoi | (aeoi ? 8'd0 : ack_mask);
    do_next  = (state_next == ST_READY) && (pend != 8'd0) && (p < s) && !ack;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_READY;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sngl             <= 1'b0;
      ic4              <= 1'b0;
      aeoi             <= 1'b0;
      read_sel         <= 1'b0;
      base             <= RESET_VECTOR_BASE[7:3];
      imr              <= RESET_MASK;
      irr              <= 8'd0;
      isr              <= 8'd0;
      irq_last         <= 8'd0;
      io_read_last     <= 1'b0;
      io_readdata      <= 8'd0;
      interrupt_do     <= 1'b0;
      interrupt_vector <= RESET_VECTOR_BASE;
    end else begin
      irq_last     <= irq_in;
      io_read_last <= io_read;
      io_readdata  <= rd_valid ? (io_address ? imr : (read_sel ? isr : irr)) : 8'd0;
      if (icw1) begin
        sngl     <= io_writedata[1];
        ic4      <= io_writedata[0];
        imr      <= 8'd0;
        isr      <= 8'd0;
        irr      <= 8'd0;
        read_sel <= 1'b0;
        aeoi     <= 1'b0;
      end else begin
        irr <= irr_next;
        isr <= isr_next;
        if (state == ST_ICW2 && wr1) base <= io_writedata[7:3];
        if (state == ST_ICW4 && wr1) aeoi <= io_writedata[1];
        if (ocw1) imr <= io_writedata;
        if (ocw3 && io_writedata[1]) read_sel <= io_writedata[0];
      end
      interrupt_do <= do_next;
      if (do_next) interrupt_vector <= {base, p[2:0]};
    end
  end

endmodule

// File: tb/tb_pic_8259_lite.sv
// Scoreboard bench for pic_8259_lite: register reads are checked from a queue of expected data,
// interrupt request/vector behaviour is checked against fixed expectations per scenario.
module tb_pic_8259_lite;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       io_address;
  logic       io_read;
  logic [7:0] io_readdata;
  logic       io_write;
  logic [7:0] io_writedata;
  logic [7:0] irq_in;
  logic       interrupt_do;
  logic [7:0] interrupt_vector;
  logic       interrupt_done;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string      tag;
    logic [7:0] val;
  } exp_t;
  exp_t exp_q[$];

  logic rd_seen, rd_last_tb;

  pic_8259_lite dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .io_address       (io_address),
    .io_read          (io_read),
    .io_readdata      (io_readdata),
    .io_write         (io_write),
    .io_writedata     (io_writedata),
    .irq_in           (irq_in),
    .interrupt_do     (interrupt_do),
    .interrupt_vector (interrupt_vector),
    .interrupt_done   (interrupt_done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  // Read-valid model: a held read counts once, data appears one cycle later
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_seen    <= 1'b0;
      rd_last_tb <= 1'b0;
    end else begin
      rd_seen    <= io_read & ~rd_last_tb;
      rd_last_tb <= io_read;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (rd_seen && exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check_eq(e.tag, io_readdata, e.val);
      end else if (!rd_seen) begin
        check_eq("rd_idle_zero", io_readdata, 8'h00);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic addr, input logic [7:0] d);
    io_address   = addr;
    io_writedata = d;
    io_write     = 1'b1;
    tick();
    io_write     = 1'b0;
  endtask

  task automatic rd(input string tag, input logic addr, input logic [7:0] exp);
    exp_t e;
    e.tag = tag;
    e.val = exp;
    exp_q.push_back(e);
    io_address = addr;
    io_read    = 1'b1;
    tick();
    io_read    = 1'b0;
    tick();
  endtask

  task automatic wait_do(input string tag, input logic [7:0] exp_vec, input int budget);
    int n;
    n = 0;
    while (!interrupt_do && n < budget) begin
      tick();
      n++;
    end
    check_eq({tag, "_do"}, 8'(interrupt_do), 8'd1);
    check_eq({tag, "_vec"}, interrupt_vector, exp_vec);
  endtask

  task automatic ack(input string tag);
    interrupt_done = 1'b1;
    tick();
    interrupt_done = 1'b0;
    check_eq({tag, "_drop"}, 8'(interrupt_do), 8'd0);
  endtask

  task automatic idle_check(input string tag, input int cycles);
    repeat (cycles) tick();
    check_eq(tag, 8'(interrupt_do), 8'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    check_eq("rst_do", 8'(interrupt_do), 8'd0);
    check_eq("rst_vec", interrupt_vector, 8'h08);
    check_eq("rst_rdata", io_readdata, 8'h00);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; io_address = 1'b0; io_read = 1'b0; io_write = 1'b0;
    io_writedata = 8'h00; irq_in = 8'h00; interrupt_done = 1'b0;
    repeat (2) tick();
    do_reset();
    rd("rst_imr", 1'b1, 8'hFF);
    rd("rst_irr", 1'b0, 8'h00);

    // Init and first vector
    wr(1'b0, 8'h13); wr(1'b1, 8'h08); wr(1'b1, 8'h01); wr(1'b1, 8'hFE);
    irq_in = 8'h01;
    wait_do("init_irq0", 8'h08, 3);
    ack("init_ack");
    irq_in = 8'h00;
    wr(1'b0, 8'h0B);
    rd("init_isr", 1'b0, 8'h01);
    wr(1'b0, 8'h20);
    rd("init_isr_eoi", 1'b0, 8'h00);

    // Priority and nesting
    wr(1'b1, 8'h00);
    irq_in = 8'h28;
    wait_do("prio_3v5", 8'h0B, 6);
    ack("prio_ack3");
    rd("prio_isr3", 1'b0, 8'h08);
    irq_in = irq_in | 8'h02;
    wait_do("nest_irq1", 8'h09, 6);
    ack("nest_ack1");
    rd("nest_isr", 1'b0, 8'h0A);
    wr(1'b0, 8'h20);
    rd("nest_isr_eoi", 1'b0, 8'h08);
    irq_in = irq_in | 8'h10;
    idle_check("block_irq4", 6);
    wr(1'b0, 8'h20);
    wait_do("unblock_irq4", 8'h0C, 6);
    ack("ack4");
    idle_check("block_irq5", 4);
    wr(1'b0, 8'h20);
    wait_do("irq5", 8'h0D, 6);
    ack("ack5");
    wr(1'b0, 8'h20);
    rd("prio_isr_clear", 1'b0, 8'h00);
    irq_in = 8'h00;

    // Read paths and held read
    wr(1'b1, 8'hFF);
    wr(1'b0, 8'h0A);
    irq_in = 8'h40;
    tick();
    idle_check("masked_irq6", 3);
    rd("rd_irr", 1'b0, 8'h40);
    rd("rd_imr", 1'b1, 8'hFF);
    begin
      exp_t e;
      e.tag = "rd_held";
      e.val = 8'h40;
      exp_q.push_back(e);
    end
    io_address = 1'b0;
    io_read    = 1'b1;
    repeat (3) tick();
    io_read    = 1'b0;
    tick();
    irq_in = 8'h00;
    tick();
    rd("rd_irr_low", 1'b0, 8'h00);

    // Edge vs level
    wr(1'b1, 8'h00);
    irq_in = 8'h04;
    wait_do("edge_irq2", 8'h0A, 6);
    ack("edge_ack2");
    wr(1'b0, 8'h20);
    idle_check("edge_no_rereq", 6);
    rd("edge_irr", 1'b0, 8'h00);
    irq_in = 8'h00;
    tick();
    irq_in = 8'h04;
    wait_do("level_irq2", 8'h0A, 6);
    irq_in = 8'h00;
    idle_check("level_drop", 3);
    rd("level_irr", 1'b0, 8'h00);

    // Masking a presented request
    irq_in = 8'h08;
    wait_do("mask_irq3", 8'h0B, 6);
    wr(1'b1, 8'h08);
    idle_check("mask_drop", 2);
    rd("mask_irr_kept", 1'b0, 8'h08);
    irq_in = 8'h00;
    wr(1'b1, 8'h00);

    // Auto-EOI
    wr(1'b0, 8'h13); wr(1'b1, 8'h08); wr(1'b1, 8'h03);
    irq_in = 8'h80;
    wait_do("aeoi_irq7", 8'h0F, 6);
    ack("aeoi_ack");
    wr(1'b0, 8'h0B);
    rd("aeoi_isr", 1'b0, 8'h00);
    irq_in = 8'h00;

    // Specific EOI
    wr(1'b0, 8'h13); wr(1'b1, 8'h08); wr(1'b1, 8'h01);
    irq_in = 8'h80;
    wait_do("seoi_irq7", 8'h0F, 6);
    ack("seoi_ack");
    wr(1'b0, 8'h0B);
    rd("seoi_isr_set", 1'b0, 8'h80);
    wr(1'b0, 8'h67);
    rd("seoi_isr_clr", 1'b0, 8'h00);
    irq_in = 8'h00;

    // ICW1 restart mid-sequence
    wr(1'b0, 8'h11); wr(1'b1, 8'h20);
    wr(1'b0, 8'h13); wr(1'b1, 8'h10); wr(1'b1, 8'h01);
    irq_in = 8'h02;
    wait_do("restart_irq1", 8'h11, 6);
    ack("restart_ack");
    irq_in = 8'h00;
    tick();

    // Reset during ICW3
    wr(1'b0, 8'h11); wr(1'b1, 8'h30);
    do_reset();
    rd("rst2_imr", 1'b1, 8'hFF);
    rd("rst2_irr", 1'b0, 8'h00);
    wr(1'b1, 8'h00);
    rd("rst2_ocw1", 1'b1, 8'h00);

    tick();
    check_eq("rd_queue_left", 8'(exp_q.size()), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
